// File: rtl/router_pkg.sv
// router_pkg: shared VC indices, arbitration mode codes and pointer sizing
package router_pkg;
  localparam int VC0 = 0;
  localparam int VC1 = 1;
  localparam int NUM_VC = 2;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pe_output_arb_if.sv
// pe_output_arb_if: ring-side requests/flits plus PE ejection handshake
interface pe_output_arb_if import router_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_IN = 2
);
  logic polarity;
  logic [NUM_VC*NUM_IN-1:0] req;
  logic [NUM_VC*NUM_IN-1:0] grant;
  logic [NUM_VC*NUM_IN*DATA_WIDTH-1:0] data_in;
  logic out_ro;
  logic out_so;
  logic [DATA_WIDTH-1:0] out_do;
  modport master(output polarity, req, data_in, out_ro, input grant, out_so, out_do);
  modport slave(input polarity, req, data_in, out_ro, output grant, out_so, out_do);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant, round-robin from ptr or fixed lowest-index priority
module rr_arbiter import router_pkg::*; #(
  parameter int NUM_IN = 2,
  parameter int ARB_MODE = ARB_RR,
  localparam int PW = ptr_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic              en,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [PW-1:0]     next_ptr
);
  int s;
  // Later writes win: wrapped candidates first, then those at/after the start point.
  always_comb begin
    grant = '0;
    next_ptr = ptr;
    s = ARB_MODE == ARB_FIXED ? 0 : int'(ptr);
    for (int i = NUM_IN - 1; i >= 0; i--)
      if (en && req[i] && i < s) begin
        grant = NUM_IN'(1) << i;
        next_ptr = ARB_MODE == ARB_FIXED ? '0 : PW'((i + 1) % NUM_IN);
      end
    for (int i = NUM_IN - 1; i >= 0; i--)
      if (en && req[i] && i >= s) begin
        grant = NUM_IN'(1) << i;
        next_ptr = ARB_MODE == ARB_FIXED ? '0 : PW'((i + 1) % NUM_IN);
      end
  end
endmodule

// File: rtl/pe_output_arb.sv
// pe_output_arb: merges per-VC ring inputs into one-entry buffers draining to the PE
module pe_output_arb import router_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_IN = 2,
  parameter int ARB_MODE = ARB_RR
) (
  input logic clk,
  input logic rst,
  pe_output_arb_if.slave bus
);
  localparam int PW = ptr_w(NUM_IN);
  logic [NUM_VC-1:0] buf_full, drain;
  logic [DATA_WIDTH-1:0] buf_q [NUM_VC];
  logic so_q;
  logic [DATA_WIDTH-1:0] do_q;
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic full, accept;
    logic [DATA_WIDTH-1:0] buffer, win;
    logic [PW-1:0] rr_ptr, nxt_ptr;
    logic [NUM_IN-1:0] g;
    assign drain[v] = full & bus.out_ro & ((v == VC1) ? bus.polarity : !bus.polarity);
    assign accept = !full | drain[v];
    assign buf_full[v] = full;
    assign buf_q[v] = buffer;
    assign bus.grant[v*NUM_IN +: NUM_IN] = g;
    rr_arbiter #(.NUM_IN(NUM_IN), .ARB_MODE(ARB_MODE)) u_arb (
      .req(bus.req[v*NUM_IN +: NUM_IN]),
      .en(accept & !rst),
      .ptr(rr_ptr),
      .grant(g),
      .next_ptr(nxt_ptr)
    );
    always_comb begin
      win = '0;
      for (int i = 0; i < NUM_IN; i++)
        if (g[i]) win = bus.data_in[(v*NUM_IN+i)*DATA_WIDTH +: DATA_WIDTH];
    end
    always_ff @(posedge clk)
      if (rst) begin
        full <= 1'b0;
        buffer <= '0;
        rr_ptr <= '0;
      end else if (|g) begin
        full <= 1'b1;
        buffer <= win;
        rr_ptr <= nxt_ptr;
      end else if (drain[v]) full <= 1'b0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      so_q <= 1'b0;
      do_q <= '0;
    end else begin
      so_q <= |drain;
      if (drain[VC1]) do_q <= buf_q[VC1];
      else if (drain[VC0]) do_q <= buf_q[VC0];
    end
  assign bus.out_so = so_q;
  assign bus.out_do = do_q;
endmodule

// File: tb/tb_pe_output_arb.sv
// tb_pe_output_arb: directed stimulus with a flit scoreboard; second instance checks fixed priority
module tb_pe_output_arb;
  localparam int DW = 64;
  localparam int NI = 3;
  logic clk = 1'b0;
  logic rst, pol, ro;
  logic [2*NI-1:0] req;
  logic [2*NI*DW-1:0] din;
  int n_tests = 0;
  int n_fail = 0;
  logic [DW-1:0] q [$];
  pe_output_arb_if #(.DATA_WIDTH(DW), .NUM_IN(NI)) b0 ();
  pe_output_arb_if #(.DATA_WIDTH(DW), .NUM_IN(NI)) b1 ();
  assign b0.polarity = pol;
  assign b0.out_ro = ro;
  assign b0.req = req;
  assign b0.data_in = din;
  assign b1.polarity = pol;
  assign b1.out_ro = ro;
  assign b1.req = req;
  assign b1.data_in = din;
  pe_output_arb #(.DATA_WIDTH(DW), .NUM_IN(NI), .ARB_MODE(0)) dut (.clk(clk), .rst(rst), .bus(b0.slave));
  pe_output_arb #(.DATA_WIDTH(DW), .NUM_IN(NI), .ARB_MODE(1)) dut_fx (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic half;
    @(negedge clk);
  endtask
  always @(negedge clk)
    if (b0.out_so === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_so: got data %0h expected no flit", b0.out_do);
      end else chk("scoreboard_out_do", b0.out_do, q.pop_front());
    end
  initial begin
    int order [4] = '{0, 1, 2, 0};
    rst = 1'b1; req = '1; ro = 1'b1; pol = 1'b0;
    for (int i = 0; i < 2*NI; i++) din[i*DW +: DW] = 64'h100 + 64'(i);
    step;
    repeat (3) begin
      half;
      chk("rst_grant", 64'(b0.grant), 0);
      chk("rst_grant_fx", 64'(b1.grant), 0);
      chk("rst_out_so", 64'(b0.out_so), 0);
      chk("rst_out_do", b0.out_do, 0);
      step;
    end
    rst = 1'b0;
    half;
    chk("first_grant", 64'(b0.grant), 6'b001001);
    q.push_back(64'h100);
    q.push_back(64'h103);
    step; req = '0;
    step; pol = 1'b1;
    step; pol = 1'b0;
    step;
    din[1*DW +: DW] = 64'hA5; req = 6'b000010;
    half;
    chk("lat_grant", 64'(b0.grant), 6'b000010);
    q.push_back(64'hA5);
    step; req = '0;
    half;
    chk("lat_t1_out_so", 64'(b0.out_so), 0);
    step; half;
    chk("lat_t2_out_so", 64'(b0.out_so), 1);
    chk("lat_t2_out_do", b0.out_do, 64'hA5);
    step; half;
    chk("lat_t3_out_so", 64'(b0.out_so), 0);
    chk("lat_t3_hold_do", b0.out_do, 64'hA5);
    rst = 1'b1; step; rst = 1'b0;
    for (int i = 0; i < NI; i++) din[i*DW +: DW] = 64'hC0 + 64'(i);
    req = 6'b000111;
    for (int k = 0; k < 4; k++) begin
      half;
      chk($sformatf("rr_grant_%0d", k), 64'(b0.grant), 64'(1) << order[k]);
      chk($sformatf("fx_grant_%0d", k), 64'(b1.grant), 1);
      q.push_back(64'hC0 + 64'(order[k]));
      step;
    end
    req = '0;
    repeat (3) step;
    ro = 1'b0; din[0] = 1'b0; din[0*DW +: DW] = 64'hE0; din[2*DW +: DW] = 64'hE2; req = 6'b000001;
    half;
    chk("bp_fill_grant", 64'(b0.grant), 6'b000001);
    q.push_back(64'hE0);
    step; req = 6'b000100;
    for (int k = 0; k < 10; k++) begin
      half;
      chk($sformatf("bp_grant_%0d", k), 64'(b0.grant), 0);
      chk($sformatf("bp_out_so_%0d", k), 64'(b0.out_so), 0);
      step;
    end
    ro = 1'b1;
    half;
    chk("bp_release_grant", 64'(b0.grant), 6'b000100);
    q.push_back(64'hE2);
    step; req = '0;
    half;
    chk("bp_release_out_so", 64'(b0.out_so), 1);
    repeat (3) step;
    din[3*DW +: DW] = 64'h1234; req = 6'b001000;
    half;
    chk("vc1_grant", 64'(b0.grant), 6'b001000);
    q.push_back(64'h1234);
    step; req = '0;
    repeat (4) begin
      half;
      chk("vc1_held_out_so", 64'(b0.out_so), 0);
      step;
    end
    pol = 1'b1;
    half;
    chk("vc1_pol_edge_out_so", 64'(b0.out_so), 0);
    step; half;
    chk("vc1_drain_out_so", 64'(b0.out_so), 1);
    chk("vc1_drain_out_do", b0.out_do, 64'h1234);
    step; pol = 1'b0;
    step;
    ro = 1'b0; req = 6'b010010;
    half;
    chk("both_fill_grant", 64'(b0.grant), 6'b010010);
    step; req = '0;
    half;
    chk("both_full_no_grant", 64'(b0.grant), 0);
    step; rst = 1'b1; req = '1;
    half;
    chk("mid_rst_grant", 64'(b0.grant), 0);
    step; rst = 1'b0; ro = 1'b1;
    half;
    chk("post_rst_grant", 64'(b0.grant), 6'b001001);
    chk("post_rst_grant_fx", 64'(b1.grant), 6'b001001);
    chk("post_rst_out_so", 64'(b0.out_so), 0);
    step; rst = 1'b1; req = '0;
    step; rst = 1'b0;
    repeat (3) begin
      half;
      chk("discard_out_so", 64'(b0.out_so), 0);
      step;
    end
    chk("scoreboard_empty", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
